uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_map_pkg.sv | 28 ++
 rtl/uart_arb_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_map_pkg.sv
// Shared UART register map, status bit positions and arbiter FSM state type.
// Used by the UART TX arbiter and its winner-select sub-module.
package uart_map_pkg;

    localparam int unsigned NUM_REQ = 2;

    localparam logic [1:0] UART_CTRL = 2'b00;
    localparam logic [1:0] UART_BAUD = 2'b01;
    localparam logic [1:0] UART_TX   = 2'b10;

    localparam int unsigned TX_IDLE_BIT = 15;

    localparam logic [15:0] UART_EN_WORD = 16'h0001;

    typedef enum logic [2:0] {
        StCfgBaud,
        StCfgEn,
        StIdle,
        StPoll,
        StWrite,
        StCheck
    } uartArbState_e;

    function automatic logic [15:0] txWord(input logic [7:0] txByte);
        return {8'h00, txByte};
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Two-requester winner select: the requester named by ptr has priority,
// the other wins only when the preferred one is idle. Grant is one-hot or zero.
module uart_arb_pick
    import uart_map_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (!ptr) begin
            if (valid[0]) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end else begin
            if (valid[1]) begin
                grant = 2'b10;
            end else if (valid[0]) begin
                grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Configures a memory-mapped UART, then serialises bytes from two requesters into it.
// Define UART_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module uart_tx_arbiter
    import uart_map_pkg::*;
#(
    parameter logic [15:0] BAUD_CFG = 16'h01B2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0Valid,
    input  logic [7:0]  i_req0Byte,
    output logic        o_req0Ready,
    input  logic        i_req1Valid,
    input  logic [7:0]  i_req1Byte,
    output logic        o_req1Ready,
    output logic [1:0]  o_memAddr,
    output logic [15:0] o_memDataOut,
    output logic        o_memWrEn,
    input  logic [15:0] i_memDataIn,
    output logic        o_cfgDone,
    output logic        o_busy
);

    uartArbState_e stateQ, stateD;
    logic [7:0]    byteQ, byteD;

    logic [NUM_REQ-1:0] valids;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] grantAcc;
    logic               ptr;
    logic               txIdle;
    logic               unusedMemBits;

    assign valids        = {i_req1Valid, i_req0Valid};
    assign txIdle        = i_memDataIn[TX_IDLE_BIT];
    assign unusedMemBits = ^i_memDataIn[TX_IDLE_BIT-1:0];

    uart_arb_pick uPick (
        .valid (valids),
        .ptr   (ptr),
        .grant (grant)
    );

    // A grant only takes effect in IDLE and never while reset is held.
    assign grantAcc = (stateQ == StIdle && !i_rst) ? grant : '0;

`ifdef UART_ARB_RR_EN
    logic ptrQ, ptrD;

    // Priority passes to the requester that did not just win.
    always_comb begin
        ptrD = ptrQ;
        if (|grantAcc) begin
            ptrD = grantAcc[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptrQ <= 1'b0;
        end else begin
            ptrQ <= ptrD;
        end
    end

    assign ptr = ptrQ;
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        byteD  = byteQ;
        case (stateQ)
            StCfgBaud: stateD = StCfgEn;
            StCfgEn:   stateD = StIdle;
            StIdle: begin
                if (|grantAcc) begin
                    byteD  = grantAcc[1] ? i_req1Byte : i_req0Byte;
                    stateD = StPoll;
                end
            end
            StPoll: begin
                if (txIdle) begin
                    stateD = StWrite;
                end
            end
            StWrite:   stateD = StCheck;
            // Still idle after the write means the UART dropped it; resend.
            StCheck:   stateD = txIdle ? StWrite : StIdle;
            default:   stateD = StCfgBaud;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateQ <= StCfgBaud;
            byteQ  <= 8'h00;
        end else begin
            stateQ <= stateD;
            byteQ  <= byteD;
        end
    end

    always_comb begin
        o_memAddr    = UART_CTRL;
        o_memDataOut = 16'h0000;
        o_memWrEn    = 1'b0;
        o_busy       = 1'b0;
        o_cfgDone    = 1'b1;
        case (stateQ)
            StCfgBaud: begin
                o_memAddr    = UART_BAUD;
                o_memDataOut = BAUD_CFG;
                o_memWrEn    = 1'b1;
                o_cfgDone    = 1'b0;
            end
            StCfgEn: begin
                o_memDataOut = UART_EN_WORD;
                o_memWrEn    = 1'b1;
                o_cfgDone    = 1'b0;
            end
            StIdle: ;
            StPoll: begin
                o_busy = 1'b1;
            end
            StWrite: begin
                o_memAddr    = UART_TX;
                o_memDataOut = txWord(byteQ);
                o_memWrEn    = 1'b1;
                o_busy       = 1'b1;
            end
            StCheck: begin
                o_busy = 1'b1;
            end
            default: begin
                o_cfgDone = 1'b0;
            end
        endcase
        // Under reset present the CFG_BAUD decode with the strobe suppressed.
        if (i_rst) begin
            o_memAddr    = UART_BAUD;
            o_memDataOut = BAUD_CFG;
            o_memWrEn    = 1'b0;
            o_busy       = 1'b0;
            o_cfgDone    = 1'b0;
        end
    end

    assign o_req0Ready = grantAcc[0];
    assign o_req1Ready = grantAcc[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(o_req0Ready && o_req1Ready));
            assert (!(o_req0Ready || o_req1Ready) || stateQ == StIdle);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected readies and UART writes are queued
// by the stimulus and popped by a negedge monitor as the DUT presents them.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic        isWrite;
        logic        who;
        logic [1:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0Valid = 1'b0;
    logic [7:0]  req0Byte = 8'h00;
    logic        req0Ready;
    logic        req1Valid = 1'b0;
    logic [7:0]  req1Byte = 8'h00;
    logic        req1Ready;
    logic [1:0]  memAddr;
    logic [15:0] memDataOut;
    logic        memWrEn;
    logic [15:0] memDataIn;
    logic        cfgDone;
    logic        busy;

    logic autoUart   = 1'b0;
    logic autoIdle   = 1'b1;
    logic manualIdle = 1'b0;

    int  checks = 0;
    int  errors = 0;
    ev_t expQ[$];

    always #5 clk = ~clk;

    // Low bits carry junk to show only the idle bit matters.
    assign memDataIn = {autoUart ? autoIdle : manualIdle, 15'h5A5A};

    // Auto mode: UART reports busy for the one cycle after each TX write.
    always @(posedge clk) autoIdle <= !(memWrEn && memAddr == 2'b10);

    uart_tx_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0Valid  (req0Valid),
        .i_req0Byte   (req0Byte),
        .o_req0Ready  (req0Ready),
        .i_req1Valid  (req1Valid),
        .i_req1Byte   (req1Byte),
        .o_req1Ready  (req1Ready),
        .o_memAddr    (memAddr),
        .o_memDataOut (memDataOut),
        .o_memWrEn    (memWrEn),
        .i_memDataIn  (memDataIn),
        .o_cfgDone    (cfgDone),
        .o_busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t readyEv(input logic who);
        return {1'b0, who, 2'b00, 16'h0000};
    endfunction

    function automatic ev_t writeEv(input logic [1:0] addr, input logic [15:0] data);
        return {1'b1, 1'b0, addr, data};
    endfunction

    task automatic popCmp(input string name, input ev_t act);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %h, expected none", name, act);
        end else begin
            e = expQ.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req0Ready && req1Ready) begin
                checks++;
                errors++;
                $display("FAIL bothReady: got 2'b11 expected at most one ready");
            end else if (req0Ready || req1Ready) begin
                popCmp("ready", readyEv(req1Ready));
            end
            if (memWrEn) begin
                popCmp("write", writeEv(memAddr, memDataOut));
            end
        end
    end

    task automatic setValid(input logic who, input logic v, input logic [7:0] b);
        if (!who) begin
            req0Valid = v;
            req0Byte  = b;
        end else begin
            req1Valid = v;
            req1Byte  = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left one tick after a posedge with the DUT in IDLE.
    task automatic xfer(input logic who, input logic [7:0] b, input int pollCycles,
                        input int drops, input bit pulseOther);
        setValid(who, 1'b1, b);
        expQ.push_back(readyEv(who));
        @(negedge clk);
        chk("idleBusy", {31'b0, busy}, 32'd0);
        step();
        setValid(who, 1'b0, 8'h00);
        for (int i = 0; i < pollCycles; i++) begin
            if (pulseOther) setValid(!who, i == 2, 8'hEE);
            @(negedge clk);
            chk("pollBusy", {31'b0, busy}, 32'd1);
            chk("pollNoWrite", {31'b0, memWrEn}, 32'd0);
            step();
        end
        if (pulseOther) setValid(!who, 1'b0, 8'h00);
        manualIdle = 1'b1;
        expQ.push_back(writeEv(2'b10, {8'h00, b}));
        step();
        for (int d = 0; d < drops; d++) begin
            step();
            expQ.push_back(writeEv(2'b10, {8'h00, b}));
            step();
        end
        manualIdle = 1'b0;
        step();
        step();
    endtask

    task automatic runConfig(input string tag);
        expQ.push_back(writeEv(2'b01, 16'h01B2));
        expQ.push_back(writeEv(2'b00, 16'h0001));
        step();
        rst = 1'b0;
        req0Valid = 1'b0;
        @(negedge clk);
        chk({tag, "CfgDone1"}, {31'b0, cfgDone}, 32'd0);
        @(negedge clk);
        chk({tag, "CfgDone2"}, {31'b0, cfgDone}, 32'd0);
        @(negedge clk);
        chk({tag, "CfgDone3"}, {31'b0, cfgDone}, 32'd1);
        chk({tag, "IdleBusy"}, {31'b0, busy}, 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a valid held to confirm ready is suppressed.
        rst = 1'b1;
        req0Valid = 1'b1;
        req0Byte  = 8'h99;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstAddr", {30'b0, memAddr}, 32'h1);
        chk("rstData", {16'b0, memDataOut}, 32'h01B2);
        chk("rstWrEn", {31'b0, memWrEn}, 32'd0);
        chk("rstReady", {30'b0, req1Ready, req0Ready}, 32'd0);
        chk("rstCfgDone", {31'b0, cfgDone}, 32'd0);
        chk("rstBusy", {31'b0, busy}, 32'd0);
        runConfig("init");

        xfer(1'b0, 8'hA5, 0, 0, 1'b0);
        // Long POLL stall with a stray pulse on the other requester.
        xfer(1'b0, 8'h5A, 10, 0, 1'b1);
        // UART drops three writes before accepting.
        xfer(1'b1, 8'h3C, 2, 3, 1'b0);

        // Both requesters valid for four back-to-back transfers.
        autoUart = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef UART_ARB_RR_EN
            expQ.push_back(readyEv(k[0]));
            expQ.push_back(writeEv(2'b10, k[0] ? 16'h0022 : 16'h0011));
`else
            expQ.push_back(readyEv(1'b0));
            expQ.push_back(writeEv(2'b10, 16'h0011));
`endif
        end
        req0Valid = 1'b1;
        req0Byte  = 8'h11;
        req1Valid = 1'b1;
        req1Byte  = 8'h22;
        repeat (16) @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        autoUart  = 1'b0;
        @(negedge clk);
        chk("contendEndBusy", {31'b0, busy}, 32'd0);
        step();

        // Reset arrives while the byte is being written.
        setValid(1'b0, 1'b1, 8'h77);
        expQ.push_back(readyEv(1'b0));
        step();
        setValid(1'b0, 1'b0, 8'h00);
        manualIdle = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstInWriteWrEn", {31'b0, memWrEn}, 32'd0);
        chk("rstInWriteReady", {30'b0, req1Ready, req0Ready}, 32'd0);
        step();
        manualIdle = 1'b0;
        @(negedge clk);
        chk("postRstCfgDone", {31'b0, cfgDone}, 32'd0);
        chk("postRstBusy", {31'b0, busy}, 32'd0);
        chk("postRstAddr", {30'b0, memAddr}, 32'h1);
        runConfig("rerun");

        xfer(1'b1, 8'hC3, 0, 1, 1'b0);

        repeat (2) @(negedge clk);
        chk("queueEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
